mem_bus_arbiter: RTL and testbench

Arbitrates the single shared memory bus port between the instruction-fetch requester (read-only) and the MEM-stage requester (LW/SW). Requests are serialised through a three-state FSM, and address/write data are latched on grant. Each requester gets a one-cycle done pulse, plus stall outputs that freeze the pipeline while its request is outstanding. The block sits between the IF/MEM stages and the external RAM bus, which has variable ack latency.

---
 rtl/mem_bus_arbiter_pkg.sv | 28 ++
 rtl/mem_bus_arbiter_if.sv | 29 ++
 rtl/mem_bus_arbiter_timeout.sv | 43 ++++
 rtl/mem_bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM states, owner IDs,
// default parameters and data constants.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_MEM = 1'b1
    } arb_owner_e;

    localparam int DEFAULT_TIMEOUT = 16;
    localparam int DEFAULT_CNT_W   = 5;

    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;

    // Stores return zero to the requester; loads return the bus word.
    function automatic logic [31:0] read_result(input logic we, input logic [31:0] rdata);
        return (we == WriteEnable) ? ZeroWord : rdata;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// External RAM bus seen by the arbiter; the arbiter is the master, the RAM the slave.
interface mem_bus_arbiter_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata,
        output bus_ack
    );

endinterface

// File: rtl/mem_bus_arbiter_timeout.sv
// Cycle counter for the bus watchdog; expired is high while the count sits at TIMEOUT-1.
module arb_timeout_counter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST_CNT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one RAM bus (MEM has priority).
// Optional bus watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               if_req,
    input  logic [31:0]        if_addr,
    output logic [31:0]        if_rdata,
    output logic               if_done,
    output logic               if_stall,
    input  logic               mem_req,
    input  logic               mem_we,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    output logic [31:0]        mem_rdata,
    output logic               mem_done,
    output logic               mem_stall,
    mem_bus_arbiter_if.master  bus,
    output logic               err_o
);

    if ((2 ** CNT_W) <= TIMEOUT) begin : g_cnt_w_check
        $error("mem_bus_arbiter: CNT_W too narrow for TIMEOUT");
    end

    arb_state_e  state_q,     state_d;
    arb_owner_e  owner_q,     owner_d;
    logic        bus_req_q,   bus_req_d;
    logic        bus_we_q,    bus_we_d;
    logic [31:0] bus_addr_q,  bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] if_rdata_q,  if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_done_q,   if_done_d;
    logic        mem_done_q,  mem_done_d;
    logic        err_q,       err_d;

`ifdef ARB_TIMEOUT_EN
    logic expired_s;
    logic cnt_clear_s;
    logic cnt_enable_s;

    assign cnt_clear_s  = (state_q != ARB_BUSY);
    assign cnt_enable_s = (state_q == ARB_BUSY) && !bus.bus_ack;

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (cnt_clear_s),
        .enable  (cnt_enable_s),
        .expired (expired_s)
    );
`endif

    // Next-state and registered-output logic; done/err are raised on entry to RESP.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (mem_req) begin
                    state_d     = ARB_BUSY;
                    owner_d     = OWNER_MEM;
                    bus_we_d    = mem_we;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                end else if (if_req) begin
                    state_d     = ARB_BUSY;
                    owner_d     = OWNER_IF;
                    bus_we_d    = WriteDisable;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = ZeroWord;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                if (bus.bus_ack) begin
                    state_d = ARB_RESP;
                    if (owner_q == OWNER_MEM) begin
                        mem_rdata_d = read_result(bus_we_q, bus.bus_rdata);
                        mem_done_d  = 1'b1;
                    end else begin
                        if_rdata_d = read_result(bus_we_q, bus.bus_rdata);
                        if_done_d  = 1'b1;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (expired_s) begin
                    state_d = ARB_RESP;
                    err_d   = 1'b1;
                    if (owner_q == OWNER_MEM) begin
                        mem_rdata_d = ZeroWord;
                        mem_done_d  = 1'b1;
                    end else begin
                        if_rdata_d = ZeroWord;
                        if_done_d  = 1'b1;
                    end
                end
`endif
                else begin
                    state_d = ARB_BUSY;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        bus_req_d = (state_d == ARB_BUSY);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWNER_IF;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            bus_wdata_q <= 32'h0000_0000;
            if_rdata_q  <= 32'h0000_0000;
            mem_rdata_q <= 32'h0000_0000;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            err_q       <= err_d;
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign if_rdata      = if_rdata_q;
    assign mem_rdata     = mem_rdata_q;
    assign if_done       = if_done_q;
    assign mem_done      = mem_done_q;
    assign err_o         = err_q;
    assign if_stall      = if_req & ~if_done_q;
    assign mem_stall     = mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus a randomized run against a
// timing/memory reference model. Timeout scenario runs when ARB_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        mem_stall;
    logic        err_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    mem_bus_arbiter_if bus_if ();

    mem_bus_arbiter #(.TIMEOUT(4), .CNT_W(3)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .if_stall  (if_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .mem_stall (mem_stall),
        .bus       (bus_if.master),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        if_req           = 1'b0;
        if_addr          = 32'h0;
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = 32'h0;
        mem_wdata        = 32'h0;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 32'h0;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 1'b0;
        tick();
        tick();
        total++;
        if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata, if_rdata, mem_rdata,
             if_done, mem_done, err_o} !== {2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000}) begin
            bad++;
            $display("FAIL reset_outputs got req=%0b we=%0b addr=%h wd=%h ird=%h mrd=%h done=%0b%0b err=%0b want all 0",
                     bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata, if_rdata, mem_rdata,
                     if_done, mem_done, err_o);
        end
        if_req = 1'b1;
        mem_req = 1'b1;
        #1;
        total++;
        if ({if_stall, mem_stall} !== 2'b11) begin
            bad++;
            $display("FAIL reset_stall got=%b want=11", {if_stall, mem_stall});
        end
        tick();
        total++;
        if (bus_if.bus_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_grant got=%0b want=0", bus_if.bus_req);
        end
        clear_inputs();
        resetn = 1'b1;
    endtask

    task automatic test_single_load();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0100;
        #1;
        total++;
        if (mem_stall !== 1'b1) begin bad++; $display("FAIL load_stall0 got=%0b want=1", mem_stall); end
        tick();
        total++;
        if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, mem_done, mem_stall} !== {2'b10, 32'h0000_0100, 2'b01}) begin
            bad++;
            $display("FAIL load_bus got req=%0b we=%0b addr=%h done=%0b stall=%0b want 1 0 00000100 0 1",
                     bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, mem_done, mem_stall);
        end
        tick();
        total++;
        if ({bus_if.bus_req, mem_done} !== 2'b10) begin
            bad++;
            $display("FAIL load_wait got req/done=%b want=10", {bus_if.bus_req, mem_done});
        end
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h1234_5678;
        tick();
        total++;
        if ({mem_done, if_done, err_o, bus_if.bus_req, mem_stall, mem_rdata} !== {5'b10000, 32'h1234_5678}) begin
            bad++;
            $display("FAIL load_done got md=%0b id=%0b err=%0b req=%0b stall=%0b rd=%h want 1 0 0 0 0 12345678",
                     mem_done, if_done, err_o, bus_if.bus_req, mem_stall, mem_rdata);
        end
        mem_req = 1'b0; bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'hAAAA_5555;
        tick();
        total++;
        if ({mem_done, mem_rdata} !== {1'b0, 32'h1234_5678}) begin
            bad++;
            $display("FAIL load_hold got done=%0b rd=%h want 0 12345678", mem_done, mem_rdata);
        end
    endtask

    task automatic test_store_zero_wait();
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0000_0200; mem_wdata = 32'hCAFE_F00D;
        bus_if.bus_rdata = 32'hDEAD_BEEF;
        tick();
        total++;
        if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata} !== {2'b11, 32'h0000_0200, 32'hCAFE_F00D}) begin
            bad++;
            $display("FAIL store_bus got req=%0b we=%0b addr=%h wd=%h want 1 1 00000200 cafef00d",
                     bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata);
        end
        bus_if.bus_ack = 1'b1;
        tick();
        total++;
        if ({mem_done, bus_if.bus_req, mem_rdata} !== {2'b10, 32'h0}) begin
            bad++;
            $display("FAIL store_done got done=%0b req=%0b rd=%h want 1 0 00000000", mem_done, bus_if.bus_req, mem_rdata);
        end
        clear_inputs();
        tick();
        total++;
        if (mem_done !== 1'b0) begin bad++; $display("FAIL store_pulse got=%0b want=0", mem_done); end
    endtask

    task automatic test_contention();
        logic [31:0] a_if, a_mem, r1, r2;
        int mem_done_cyc;
        a_if = $urandom & 32'hFFFF_FFFC; a_mem = $urandom & 32'hFFFF_FFFC;
        r1 = $urandom; r2 = $urandom;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = a_mem;
        if_req = 1'b1; if_addr = a_if;
        tick();
        total++;
        if ({bus_if.bus_req, bus_if.bus_addr, if_stall} !== {1'b1, a_mem, 1'b1}) begin
            bad++;
            $display("FAIL cont_mem_first got req=%0b addr=%h istall=%0b want 1 %h 1", bus_if.bus_req, bus_if.bus_addr, if_stall, a_mem);
        end
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = r1;
        tick();
        mem_done_cyc = cyc;
        total++;
        if ({mem_done, if_done, if_stall, mem_rdata} !== {3'b101, r1}) begin
            bad++;
            $display("FAIL cont_mem_done got md=%0b id=%0b istall=%0b rd=%h want 1 0 1 %h", mem_done, if_done, if_stall, mem_rdata, r1);
        end
        mem_req = 1'b0; bus_if.bus_ack = 1'b0;
        tick();
        total++;
        if ({bus_if.bus_req, if_stall} !== 2'b01) begin
            bad++;
            $display("FAIL cont_gap got req/istall=%b want=01", {bus_if.bus_req, if_stall});
        end
        tick();
        total++;
        if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr} !== {2'b10, a_if}) begin
            bad++;
            $display("FAIL cont_if_bus got req=%0b we=%0b addr=%h want 1 0 %h", bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, a_if);
        end
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = r2;
        tick();
        total++;
        if ({if_done, mem_done, if_rdata, mem_rdata} !== {2'b10, r2, r1} || (cyc - mem_done_cyc) != 3) begin
            bad++;
            $display("FAIL cont_if_done got id=%0b md=%0b ird=%h mrd=%h gap=%0d want 1 0 %h %h 3",
                     if_done, mem_done, if_rdata, mem_rdata, cyc - mem_done_cyc, r2, r1);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int done_cyc [3];
        logic [31:0] exp_rd;
        exp_rd = 32'h0;
        if_req = 1'b1; if_addr = 32'h0;
        for (int k = 0; k < 30 && n < 3; k++) begin
            tick();
            bus_if.bus_ack = 1'b0;
            if (if_done === 1'b1) begin
                total++;
                if (if_rdata !== exp_rd) begin
                    bad++;
                    $display("FAIL b2b_rdata n=%0d got=%h want=%h", n, if_rdata, exp_rd);
                end
                done_cyc[n] = cyc;
                n++;
                if (n < 3) if_addr = 32'(4 * n);
                else if_req = 1'b0;
            end else if (bus_if.bus_req === 1'b1) begin
                total++;
                if (bus_if.bus_addr !== 32'(4 * n)) begin
                    bad++;
                    $display("FAIL b2b_addr n=%0d got=%h want=%h", n, bus_if.bus_addr, 32'(4 * n));
                end
                exp_rd = $urandom;
                bus_if.bus_ack = 1'b1;
                bus_if.bus_rdata = exp_rd;
            end
        end
        total++;
        if (n != 3) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=3", n);
        end else begin
            total++;
            if ((done_cyc[1] - done_cyc[0]) != 3 || (done_cyc[2] - done_cyc[1]) != 3) begin
                bad++;
                $display("FAIL b2b_spacing got=%0d,%0d want=3,3", done_cyc[1] - done_cyc[0], done_cyc[2] - done_cyc[1]);
            end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_busy();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0300;
        tick();
        total++;
        if (bus_if.bus_req !== 1'b1) begin bad++; $display("FAIL rst_busy_req got=%0b want=1", bus_if.bus_req); end
        resetn = 1'b0; mem_req = 1'b0;
        tick();
        resetn = 1'b1;
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h5A5A_A5A5;
        tick();
        total++;
        if ({bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata, if_rdata, mem_rdata,
             if_done, mem_done, err_o} !== {2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000}) begin
            bad++;
            $display("FAIL rst_busy_outputs got req=%0b addr=%h ird=%h mrd=%h done=%0b%0b err=%0b want all 0",
                     bus_if.bus_req, bus_if.bus_addr, if_rdata, mem_rdata, if_done, mem_done, err_o);
        end
        bus_if.bus_ack = 1'b0;
        tick();
        total++;
        if ({if_done, mem_done, bus_if.bus_req} !== 3'b000) begin
            bad++;
            $display("FAIL rst_busy_late_ack got=%b want=000", {if_done, mem_done, bus_if.bus_req});
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0400;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++;
            if ({bus_if.bus_req, mem_done} !== 2'b10) begin
                bad++;
                $display("FAIL tmo_ack4_wait cycle=%0d got=%b want=10", i, {bus_if.bus_req, mem_done});
            end
        end
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h0BAD_CAFE;
        tick();
        total++;
        if ({mem_done, err_o, mem_rdata} !== {2'b10, 32'h0BAD_CAFE}) begin
            bad++;
            $display("FAIL tmo_ack4_done got done=%0b err=%0b rd=%h want 1 0 0badcafe", mem_done, err_o, mem_rdata);
        end
        mem_req = 1'b0; bus_if.bus_ack = 1'b0;
        tick();
        mem_req = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++;
            if ({mem_done, err_o} !== 2'b00) begin
                bad++;
                $display("FAIL tmo_wait cycle=%0d got=%b want=00", i, {mem_done, err_o});
            end
        end
        tick();
        total++;
        if ({mem_done, err_o, bus_if.bus_req, mem_rdata} !== {3'b110, 32'h0}) begin
            bad++;
            $display("FAIL tmo_expire got done=%0b err=%0b req=%0b rd=%h want 1 1 0 0", mem_done, err_o, bus_if.bus_req, mem_rdata);
        end
        clear_inputs();
        tick();
        total++;
        if (err_o !== 1'b0) begin bad++; $display("FAIL tmo_err_pulse got=%0b want=0", err_o); end
    endtask
`endif

    // Reference: grant one cycle after the arbiter is free with a request pending
    // (MEM first), ack after a random 0..3 BUSY cycles, done the cycle after ack,
    // free again the cycle after done. Loads return the reference memory word.
    task automatic test_random();
        logic [31:0] ref_mem [64];
        logic [31:0] x_addr, x_wdata, exp_rd, exp_if_rd, exp_mem_rd;
        logic        x_we, own_mem, active, exp_req, e_if_done, e_mem_done;
        int t, free_from, g_cyc, a_cyc, d_cyc, served;
        for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
        clear_inputs();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        t = 0; free_from = 0; served = 0; active = 1'b0;
        g_cyc = 0; a_cyc = 0; d_cyc = 0; own_mem = 1'b0;
        x_addr = 32'h0; x_wdata = 32'h0; x_we = 1'b0; exp_rd = 32'h0;
        exp_if_rd = 32'h0; exp_mem_rd = 32'h0;
        for (int n = 0; n < 1500 && served < 40; n++) begin
            tick();
            t++;
            exp_req    = active && (t >= g_cyc) && (t <= a_cyc);
            e_mem_done = active && (t == d_cyc) && own_mem;
            e_if_done  = active && (t == d_cyc) && !own_mem;
            if (e_mem_done) exp_mem_rd = exp_rd;
            if (e_if_done)  exp_if_rd  = exp_rd;
            total++;
            if (bus_if.bus_req !== exp_req) begin
                bad++;
                $display("FAIL rnd_bus_req t=%0d got=%0b want=%0b", t, bus_if.bus_req, exp_req);
            end
            if (exp_req) begin
                total++;
                if ({bus_if.bus_we, bus_if.bus_addr} !== {x_we, x_addr} || (x_we && bus_if.bus_wdata !== x_wdata)) begin
                    bad++;
                    $display("FAIL rnd_bus_fields t=%0d got we=%0b addr=%h wd=%h want we=%0b addr=%h wd=%h",
                             t, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata, x_we, x_addr, x_wdata);
                end
            end
            total++;
            if ({if_done, mem_done, err_o, if_rdata, mem_rdata} !== {e_if_done, e_mem_done, 1'b0, exp_if_rd, exp_mem_rd}) begin
                bad++;
                $display("FAIL rnd_resp t=%0d got id=%0b md=%0b err=%0b ird=%h mrd=%h want %0b %0b 0 %h %h",
                         t, if_done, mem_done, err_o, if_rdata, mem_rdata, e_if_done, e_mem_done, exp_if_rd, exp_mem_rd);
            end
            if (active && t == d_cyc) begin
                active = 1'b0;
                served++;
            end
            // Requesters: hold until done, then drop or issue a fresh request.
            if (e_mem_done) begin
                if ($urandom_range(0, 1) == 0) mem_req = 1'b0;
                else begin mem_addr = $urandom & 32'hFFFF_FFFC; mem_we = 1'($urandom_range(0, 1)); mem_wdata = $urandom; end
            end else if (!mem_req && $urandom_range(0, 3) == 0) begin
                mem_req = 1'b1; mem_addr = $urandom & 32'hFFFF_FFFC; mem_we = 1'($urandom_range(0, 1)); mem_wdata = $urandom;
            end
            if (e_if_done) begin
                if ($urandom_range(0, 1) == 0) if_req = 1'b0;
                else if_addr = $urandom & 32'hFFFF_FFFC;
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            #1;
            total++;
            if ({if_stall, mem_stall} !== {if_req & ~e_if_done, mem_req & ~e_mem_done}) begin
                bad++;
                $display("FAIL rnd_stall t=%0d got=%b want=%b", t, {if_stall, mem_stall}, {if_req & ~e_if_done, mem_req & ~e_mem_done});
            end
            if (!active && t >= free_from && (mem_req || if_req)) begin
                active  = 1'b1;
                own_mem = mem_req;
                x_addr  = own_mem ? mem_addr : if_addr;
                x_we    = own_mem ? mem_we : 1'b0;
                x_wdata = mem_wdata;
                g_cyc   = t + 1;
                a_cyc   = g_cyc + int'($urandom_range(0, 3));
                d_cyc   = a_cyc + 1;
                free_from = d_cyc + 1;
            end
            // Bus slave: ack at the planned cycle, random ignored acks outside BUSY.
            if (active && t == a_cyc) begin
                bus_if.bus_ack = 1'b1;
                if (x_we) begin
                    ref_mem[x_addr[7:2]] = x_wdata;
                    exp_rd = 32'h0;
                    bus_if.bus_rdata = $urandom;
                end else begin
                    exp_rd = ref_mem[x_addr[7:2]];
                    bus_if.bus_rdata = exp_rd;
                end
            end else begin
                bus_if.bus_ack = ($urandom_range(0, 3) == 0) && !(active && t >= g_cyc && t < a_cyc);
                bus_if.bus_rdata = $urandom;
            end
        end
        total++;
        if (served < 40) begin
            bad++;
            $display("FAIL rnd_progress got=%0d want=40", served);
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        resetn = 1'b0;
        clear_inputs();
        test_reset();
        test_single_load();
        test_store_zero_wait();
        test_contention();
        test_back_to_back();
        test_reset_mid_busy();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
